// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and the decoded-field bundle used by instr_encoder.
package rv_isa_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S, FMT_R, FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } enc_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with encodability flag.
// Immediate/funct7 range checking is present only when ENC_RANGE_CHECK_EN is defined.
module instr_pack
  import rv_isa_pkg::*;
(
  input  enc_fields_t fields,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e        fmt;
  logic        range_err;
  logic [31:0] imm;

  assign imm = fields.imm;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fmt = FMT_BAD;
    unique case (fields.opcode)
      OP_LUI, OP_AUIPC:  fmt = FMT_U;
      OP_JAL:            fmt = FMT_J;
      OP_JALR, OP_LOAD:  fmt = FMT_I;
      OP_IMM:            fmt = (fields.funct3 == 3'b001 || fields.funct3 == 3'b101) ? FMT_SH : FMT_I;
      OP_BRANCH:         fmt = FMT_B;
      OP_STORE:          fmt = FMT_S;
      OP_REG:            fmt = FMT_R;
      default:           fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    instr = RV_NOP;
    unique case (fmt)
      FMT_U:  instr = {imm[31:12], fields.rd, fields.opcode};
      FMT_J:  instr = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
      FMT_I:  instr = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_SH: instr = {fields.funct7, fields.shamt, fields.rs1, fields.funct3, fields.rd,
                       fields.opcode};
      FMT_B:  instr = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3, imm[4:1],
                       imm[11], fields.opcode};
      FMT_S:  instr = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
      FMT_R:  instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd,
                       fields.opcode};
      default: instr = RV_NOP;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Fields are still packed truncated; this only reports that information was lost.
  always_comb begin
    range_err = 1'b0;
    unique case (fmt)
      FMT_I, FMT_S: range_err = (imm != {{20{imm[11]}}, imm[11:0]});
      FMT_B:        range_err = imm[0] | (imm != {{19{imm[12]}}, imm[12:0]});
      FMT_J:        range_err = imm[0] | (imm != {{11{imm[20]}}, imm[20:0]});
      FMT_U:        range_err = |imm[11:0];
      FMT_SH:       range_err = (fields.funct7 != 7'b0000000) && (fields.funct7 != 7'b0100000);
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err = (fmt == FMT_BAD) | range_err;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with sequential byte addressing.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        e_opcode,
  input  logic [4:0]        e_rd,
  input  logic [4:0]        e_rs1,
  input  logic [4:0]        e_rs2,
  input  logic [31:0]       e_imm,
  input  logic [4:0]        e_shamt,
  input  logic [2:0]        e_funct3,
  input  logic [6:0]        e_funct7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       enc_count
);

  enc_fields_t       in_fields, s1_fields_d, s1_fields_q;
  logic              s1_valid_d, s1_valid_q;
  logic              s2_valid_d, s2_valid_q;
  logic [31:0]       out_instr_d, out_instr_q;
  logic              out_err_d, out_err_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [15:0]       count_d, count_q;
  logic [31:0]       pack_instr;
  logic              pack_err;
  logic              out_xfer, s1_advance, in_xfer;

  assign in_fields = '{opcode: e_opcode, rd: e_rd, rs1: e_rs1, rs2: e_rs2, imm: e_imm,
                       shamt: e_shamt, funct3: e_funct3, funct7: e_funct7};

  instr_pack u_pack (
    .fields (s1_fields_q),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  always_comb begin
    // Flush overrides every handshake in the same cycle.
    out_xfer    = s2_valid_q & out_ready & ~flush;
    s1_advance  = s1_valid_q & (~s2_valid_q | out_xfer) & ~flush;
    in_ready    = (~s1_valid_q | s1_advance) & ~flush;
    in_xfer     = in_valid & in_ready;

    s1_valid_d  = s1_valid_q;
    s1_fields_d = s1_fields_q;
    s2_valid_d  = s2_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    addr_d      = addr_q;
    count_d     = count_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      addr_d     = BASE_ADDR;
      count_d    = '0;
    end else begin
      if (in_xfer) begin
        s1_valid_d  = 1'b1;
        s1_fields_d = in_fields;
      end else if (s1_advance) begin
        s1_valid_d = 1'b0;
      end

      if (s1_advance) begin
        s2_valid_d  = 1'b1;
        out_instr_d = pack_instr;
        out_err_d   = pack_err;
      end else if (out_xfer) begin
        s2_valid_d = 1'b0;
      end

      if (out_xfer) begin
        addr_d = addr_q + ADDR_W'(4);
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_fields_q <= s1_fields_d;
  end

  assign out_valid = s2_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_addr  = addr_q;
  assign enc_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed test-plan cases plus randomized traffic.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  BASE   = 8'hFC;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [6:0]  e_opcode, e_funct7;
  logic [4:0]  e_rd, e_rs1, e_rs2, e_shamt;
  logic [31:0] e_imm, out_instr;
  logic [2:0]  e_funct3;
  logic [7:0]  out_addr;
  logic [15:0] enc_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .e_opcode(e_opcode), .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_imm(e_imm),
    .e_shamt(e_shamt), .e_funct3(e_funct3), .e_funct7(e_funct7),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sh(input logic [31:0] v, input int n);
    return v << n;
  endfunction

  // Reference: places each field at its ISA bit position; range rules use signed arithmetic.
  function automatic exp_t model(input bundle_t b);
    exp_t        e;
    int          s;
    logic [31:0] base_r;
    logic [31:0] i;
    bit          bad;
    i      = b.imm;
    s      = $signed(b.imm);
    bad    = 1'b0;
    base_r = sh(32'(b.f3), 12) | sh(32'(b.rs1), 15) | 32'(b.op);
    case (b.op)
      7'b0110111, 7'b0010111: begin
        e.instr = (i & 32'hFFFF_F000) | sh(32'(b.rd), 7) | 32'(b.op);
        bad = (i % 4096) != 0;
      end
      7'b1101111: begin
        e.instr = 32'(b.op) | sh(32'(b.rd), 7) | sh((i >> 12) & 32'hFF, 12)
                | sh((i >> 11) & 1, 20) | sh((i >> 1) & 32'h3FF, 21) | sh((i >> 20) & 1, 31);
        bad = i[0] || s < -(1 << 20) || s >= (1 << 20);
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        if (b.op == 7'b0010011 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
          e.instr = base_r | sh(32'(b.rd), 7) | sh(32'(b.shamt), 20) | sh(32'(b.f7), 25);
          bad = !(b.f7 == 7'd0 || b.f7 == 7'd32);
        end else begin
          e.instr = base_r | sh(32'(b.rd), 7) | sh(i & 32'hFFF, 20);
          bad = s < -2048 || s > 2047;
        end
      end
      7'b1100011: begin
        e.instr = base_r | sh((i >> 11) & 1, 7) | sh((i >> 1) & 32'hF, 8)
                | sh(32'(b.rs2), 20) | sh((i >> 5) & 32'h3F, 25) | sh((i >> 12) & 1, 31);
        bad = i[0] || s < -4096 || s > 4095;
      end
      7'b0100011: begin
        e.instr = base_r | sh(i & 32'h1F, 7) | sh(32'(b.rs2), 20) | sh((i >> 5) & 32'h7F, 25);
        bad = s < -2048 || s > 2047;
      end
      7'b0110011: e.instr = base_r | sh(32'(b.rd), 7) | sh(32'(b.rs2), 20) | sh(32'(b.f7), 25);
      default: begin
        e.instr = 32'h0000_0013;
        e.err   = 1'b1;
        return e;
      end
    endcase
    e.err = RANGE_EN && bad;
    return e;
  endfunction

  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic [2:0] f3, input logic [6:0] f7);
    bundle_t b;
    b = '{op: op, rd: rd, rs1: rs1, rs2: rs2, shamt: 5'(imm), imm: imm, f3: f3, f7: f7};
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    logic [6:0] ops[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    bundle_t b;
    b.op    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    b.rd    = 5'($urandom);
    b.rs1   = 5'($urandom);
    b.rs2   = 5'($urandom);
    b.shamt = 5'($urandom);
    b.f3    = 3'($urandom);
    b.imm   = $urandom_range(0, 1) ? 32'($signed(12'($urandom))) : $urandom;
    case ($urandom_range(0, 2))
      0:       b.f7 = 7'd0;
      1:       b.f7 = 7'd32;
      default: b.f7 = 7'($urandom);
    endcase
    return b;
  endfunction

  task automatic apply(input bundle_t b);
    e_opcode = b.op;  e_rd = b.rd;       e_rs1 = b.rs1;   e_rs2 = b.rs2;
    e_imm    = b.imm; e_shamt = b.shamt; e_funct3 = b.f3; e_funct7 = b.f7;
  endtask

  // Offers one bundle until accepted; returns one time unit after the accepting edge.
  task automatic send(input bundle_t b);
    int n = 0;
    apply(b);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) sb_q.push_back(model(b));
    else check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [31:0] ei, input logic ee,
                          input logic [7:0] ea);
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({nm, "_timeout"}, 32'(out_valid), 32'd1);
    else begin
      check({nm, "_instr"}, out_instr, ei);
      check({nm, "_err"}, 32'(out_err), 32'(ee));
      check({nm, "_addr"}, 32'(out_addr), 32'(ea));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Monitor: scoreboard pops on every output transfer; also checks hold stability.
  initial begin
    logic [7:0]  exp_addr;
    logic [15:0] exp_cnt;
    logic        hold_v;
    logic [31:0] hold_instr;
    logic [7:0]  hold_addr;
    logic        hold_err;
    exp_t        e;
    exp_addr = BASE;
    exp_cnt  = '0;
    hold_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_addr = BASE;
        exp_cnt  = '0;
        hold_v   = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_instr", out_instr, hold_instr);
          check("hold_addr", 32'(out_addr), 32'(hold_addr));
          check("hold_err", 32'(out_err), 32'(hold_err));
          hold_v = 1'b0;
        end
        if (flush) begin
          sb_q.delete();
          exp_addr = BASE;
          exp_cnt  = '0;
        end else if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h expected no word", out_instr);
          end else begin
            e = sb_q.pop_front();
            check("sb_instr", out_instr, e.instr);
            check("sb_err", 32'(out_err), 32'(e.err));
            check("sb_addr", 32'(out_addr), 32'(exp_addr));
            check("sb_count", 32'(enc_count), 32'(exp_cnt));
          end
          exp_addr = exp_addr + 8'd4;
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end else if (out_valid) begin
          hold_v     = 1'b1;
          hold_instr = out_instr;
          hold_addr  = out_addr;
          hold_err   = out_err;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bundle_t b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply(mk(7'h0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'(BASE));
    check("rst_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1;

    // ADDI x1,x0,5 with two-cycle latency.
    out_ready = 1'b1;
    send(mk(7'h13, 5'd1, 5'd0, 5'd0, 32'd5, 3'd0, 7'd0));
    @(negedge clk);
    check("addi_lat1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("addi_lat2_valid", 32'(out_valid), 32'd1);
    check("addi_instr", out_instr, 32'h0050_0093);
    check("addi_addr", 32'(out_addr), 32'(BASE));
    check("addi_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;

    // JAL then BEQ from a restarted address; second address wraps past 0xFC.
    do_flush();
    send(mk(7'h6F, 5'd1, 5'd0, 5'd0, 32'd8, 3'd0, 7'd0));
    send(mk(7'h63, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 3'd0, 7'd0));
    wait_out("jal", 32'h0080_00EF, 1'b0, BASE);
    wait_out("beq", 32'hFE20_8EE3, 1'b0, BASE + 8'd4);
    check("beq_enc_count", 32'(enc_count), 32'd2);

    send(mk(7'h7F, 5'd3, 5'd4, 5'd5, 32'h1234, 3'd2, 7'd9));
    wait_out("badop", 32'h0000_0013, 1'b1, BASE + 8'd8);
`ifdef ENC_RANGE_CHECK_EN
    send(mk(7'h13, 5'd1, 5'd0, 5'd0, 32'd2048, 3'd0, 7'd0));
    wait_out("addi_range", 32'h8000_0093, 1'b1, BASE + 8'd12);
`endif

    // Backpressure: two bundles fill the pipe, the third stalls until release.
    do_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b = rand_bundle();
      apply(b);
      @(negedge clk);
      check("bp_accept", 32'(in_ready), 32'd1);
      if (in_ready) sb_q.push_back(model(b));
      @(posedge clk); #1;
    end
    b = rand_bundle();
    apply(b);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_stall", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(b);
    repeat (4) @(posedge clk);
    #1;
    check("bp_enc_count", 32'(enc_count), 32'd3);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Flush with two words in flight.
    out_ready = 1'b0;
    send(rand_bundle());
    send(rand_bundle());
    flush = 1'b1;
    in_valid = 1'b1;
    apply(rand_bundle());
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(7'h33, 5'd7, 5'd8, 5'd9, 32'd0, 3'd0, 7'h20));
    wait_out("post_flush", 32'h4094_03B3, 1'b0, BASE);

    // Randomized traffic with random backpressure and occasional flush.
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      b = rand_bundle();
      apply(b);
      @(negedge clk);
      if (in_valid && in_ready) sb_q.push_back(model(b));
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Takes decoded RV32I fields and packs them into 32-bit instruction words.
- Used by the boot/program loader and the self-test harness to write instruction memory.
- Two-stage valid/ready pipeline with throughput of 1 word/cycle.
- Assigns each emitted word a sequential byte address and flags fields that cannot be encoded.

Parameters:
- BASE_ADDR, 32'h0000_0000, first output address after reset or flush.
- ADDR_W, 32, width of out_addr; the address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline clear and address restart.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept the bundle.
- e_opcode  in  7  opcode.
- e_rd / e_rs1 / e_rs2  in  5 each  register indices.
- e_imm  in  32  sign-extended immediate, as produced by the decoder.
- e_shamt  in  5  shift amount.
- e_funct3  in  3  funct3.
- e_funct7  in  7  funct7.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- out_err  out  1  fields were not encodable.
- enc_count  out  16  number of words emitted, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_instr=0, out_err=0.
  - out_addr=BASE_ADDR, enc_count=0.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Once out_valid=1, out_instr, out_addr and out_err stay stable until the transfer.
- Pipeline:
  - S1 registers the raw fields.
  - S2 registers the packed word and the error flag.
  - A stage advances when the next stage is empty or is transferring in the same cycle.
  - in_ready = !s1_valid | s1_advance; it is combinational from out_ready.
  - Latency is 2 cycles from input transfer to out_valid when there is no backpressure.
- Packing by opcode:
  - LUI/AUIPC (0110111/0010111): {imm[31:12], rd, op}.
  - JAL (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - JALR (1100111), loads (0000011), OP-IMM with funct3 not in {001,101}: {imm[11:0], rs1, f3, rd, op}.
  - OP-IMM with funct3 001/101 (shifts): {funct7, shamt, rs1, f3, rd, op}.
  - Branch (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - Store (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - OP (0110011): {funct7, rs2, rs1, f3, rd, op}.
  - Any other opcode: out_instr = 32'h0000_0013 (NOP) and out_err=1.
- Addressing:
  - out_addr increments by 4 on each output transfer and wraps silently past 2^ADDR_W-4.
  - enc_count increments on each output transfer and saturates at 16'hFFFF.
- Flush:
  - Clears s1_valid and s2_valid.
  - Sets out_addr=BASE_ADDR and enc_count=0.
  - In a flush cycle, in_ready=0 and no transfer is counted, even if out_ready=1.
  - Flush beats any simultaneous handshake.
- Reset mid-transfer discards all in-flight words, with the same effect as flush.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- Defined:
  - out_err also asserts for immediate range violations:
    - I/S: imm is not a sign-extension of imm[11:0].
    - B: imm[0]≠0, or imm is not a sign-extension of 13 bits.
    - J: imm[0]≠0, or imm is not a sign-extension of 21 bits.
    - U: imm[11:0]≠0.
    - Shift: funct7 is not 0000000 or 0100000.
  - The word is still emitted with truncated fields.
- Undefined: out_err asserts only for an unsupported opcode, and the range logic is absent.

Decomposition:
- Package rv_isa_pkg holds:
  - Opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - RV_NOP = 32'h0000_0013.
- Sub-module instr_pack: purely combinational packer plus error logic, placed between S1 and S2.

Test Plan:
- ADDI x1,x0,5: opcode 0010011, rd=1, rs1=0, f3=0, imm=5, out_ready=1 → out_instr=0x0050_0093, out_addr=BASE_ADDR, out_err=0, out_valid 2 cycles after the input transfer.
- JAL x1 imm=8 → 0x0080_00EF. Then BEQ x1,x2 imm=-4 (32'hFFFF_FFFC) → 0xFE20_8EE3 at BASE_ADDR+4; enc_count=2.
- Unsupported opcode 7'h7F → out_instr=0x0000_0013, out_err=1. With ENC_RANGE_CHECK_EN: ADDI imm=2048 → out_err=1, out_instr=0x8000_0093.
- Backpressure: hold out_ready=0 and offer 3 bundles → 2 accepted, then in_ready=0. Release out_ready → words appear in order at BASE, +4, +8 with no loss and no duplication.
- Flush with 2 words in flight and in_valid=1 → that cycle's in_ready=0. Next cycle out_valid=0, enc_count=0. The next word comes out at BASE_ADDR.
- Preload out_addr to 2^ADDR_W-4 (via ADDR_W=8, BASE_ADDR=8'hFC) and emit 2 words → addresses 0xFC, then 0x00.
